// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding and the
// ASCII constants sent as the CR/LF trailer.
// Optional feature macro: UART_ARB_CRLF_EN adds the CR and LF states.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StSend  = 3'd2,
    StWait  = 3'd3
`ifdef UART_ARB_CRLF_EN
    ,
    StCr    = 3'd4,
    StLf    = 3'd5
`endif
  } arb_state_e;

`ifdef UART_ARB_CRLF_EN
  // Progress through the CR/LF trailer that follows the last data byte
  typedef enum logic [1:0] {
    TailNone = 2'd0,
    TailCr   = 2'd1,
    TailLf   = 2'd2
  } tail_e;
`endif

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after the pointer, wrapping modulo NUM_REQ (which need not be a power of 2).
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Scan NUM_REQ candidates starting at ptr_i; first hit wins
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART_TX among NUM_REQ
// valid/ready byte streams. A granted requester owns the UART until its
// last byte has finished on the line.
// Optional feature macro: UART_ARB_CRLF_EN appends CR, LF after each packet.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [NUM_REQ*8-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done,
  output logic                 o_Busy
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic               last_flag_q;
  logic [7:0]         tx_byte_q;
`ifdef UART_ARB_CRLF_EN
  tail_e              tail_q;
`endif

  logic [7:0]         req_byte [NUM_REQ];
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   rr_ptr_next;
  logic               arb_start;
  logic               byte_accept;
  logic               tx_done_wait;
  logic               pkt_release;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_byte[k] = i_Req_Byte[8*k +: 8];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i (i_Req_Valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // Do not start a new packet while a byte (e.g. one left over from reset) is on the line
  assign arb_start    = (state_q == StIdle) && (|i_Req_Valid) && !i_TX_Active;
  assign byte_accept  = (state_q == StFetch) && i_Req_Valid[gidx_q];
  assign tx_done_wait = (state_q == StWait) && i_TX_Done;
  assign rr_ptr_next  = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
`ifdef UART_ARB_CRLF_EN
  assign pkt_release  = tx_done_wait && last_flag_q && (tail_q == TailLf);
`else
  assign pkt_release  = tx_done_wait && last_flag_q;
`endif

  // State register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (arb_start) state_d = StFetch;
      StFetch: if (byte_accept) state_d = StSend;
      StSend:  state_d = StWait;
      StWait: begin
        if (i_TX_Done) begin
          if (!last_flag_q) begin
            state_d = StFetch;
          end else begin
`ifdef UART_ARB_CRLF_EN
            case (tail_q)
              TailNone: state_d = StCr;
              TailCr:   state_d = StLf;
              default:  state_d = StIdle;
            endcase
`else
            state_d = StIdle;
`endif
          end
        end
      end
`ifdef UART_ARB_CRLF_EN
      StCr:    state_d = StWait;
      StLf:    state_d = StWait;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Grant, round-robin pointer, byte and last-flag registers
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      last_flag_q <= 1'b0;
      tx_byte_q   <= 8'h00;
`ifdef UART_ARB_CRLF_EN
      tail_q      <= TailNone;
`endif
    end else begin
      if (arb_start) begin
        grant_q <= pick_gnt;
        gidx_q  <= pick_idx;
      end
      if (byte_accept) begin
        tx_byte_q   <= req_byte[gidx_q];
        last_flag_q <= i_Req_Last[gidx_q];
      end
`ifdef UART_ARB_CRLF_EN
      // Trailer byte is loaded one cycle ahead so it is stable during its DV pulse
      if (tx_done_wait && last_flag_q) begin
        case (tail_q)
          TailNone: begin
            tail_q    <= TailCr;
            tx_byte_q <= CHR_CR;
          end
          TailCr: begin
            tail_q    <= TailLf;
            tx_byte_q <= CHR_LF;
          end
          default: tail_q <= TailNone;
        endcase
      end
`endif
      if (pkt_release) begin
        grant_q     <= '0;
        rr_ptr_q    <= rr_ptr_next;
        last_flag_q <= 1'b0;
      end
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    o_TX_DV     = 1'b0;
    o_Req_Ready = '0;
    case (state_q)
      StFetch: o_Req_Ready = grant_q;
      StSend:  o_TX_DV     = 1'b1;
`ifdef UART_ARB_CRLF_EN
      StCr:    o_TX_DV     = 1'b1;
      StLf:    o_TX_DV     = 1'b1;
`endif
      default: ;
    endcase
  end

  assign o_Busy    = (state_q != StIdle);
  assign o_Grant   = grant_q;
  assign o_TX_Byte = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a behavioural
// UART_TX model and per-requester packet sources.
// Honours UART_ARB_CRLF_EN when the design is built with it.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int FRAME   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_byte;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active   = 1'b0;
  logic        tx_done     = 1'b0;
  logic        glitch_done = 1'b0;
  logic        busy;

  int n_cmp  = 0;
  int n_err  = 0;
  int rd_ptr = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Req_Valid (req_valid),
    .i_Req_Byte  (req_byte),
    .i_Req_Last  (req_last),
    .o_Req_Ready (req_ready),
    .o_Grant     (grant),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .i_TX_Active (tx_active),
    .i_TX_Done   (tx_done | glitch_done),
    .o_Busy      (busy)
  );

  // Packet sources: queue entries are {last, byte}
  logic [8:0] src_q [NUM_REQ][$];
  logic [3:0] hold = 4'b0;
  logic [3:0] hs   = 4'b0;
  int         acc_cnt [NUM_REQ];

  always @(negedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (hs[k] && src_q[k].size() > 0) begin
        void'(src_q[k].pop_front());
        acc_cnt[k]++;
      end
      req_valid[k]          = (src_q[k].size() > 0) && !hold[k];
      req_byte[8*k +: 8]    = (src_q[k].size() > 0) ? src_q[k][0][7:0] : 8'h00;
      req_last[k]           = (src_q[k].size() > 0) ? src_q[k][0][8] : 1'b0;
      hs[k]                 = req_valid[k] && req_ready[k] && !rst;
    end
  end

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    if ($countones(v) == 1) begin
      for (int k = 0; k < 4; k++) if (v[k]) r = k;
    end
    return r;
  endfunction

  // UART_TX model plus line log and DV-width monitor
  logic [7:0] log_byte [$];
  int         log_gnt  [$];
  int         frame_cnt = 0;
  int         dv_wide   = 0;
  logic       dv_prev   = 1'b0;

  always @(posedge clk) begin
    tx_done <= 1'b0;
    dv_prev <= tx_dv;
    if (tx_dv && dv_prev) dv_wide <= dv_wide + 1;
    if (tx_active) begin
      if (frame_cnt == FRAME - 1) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
      end else begin
        frame_cnt <= frame_cnt + 1;
      end
    end else if (tx_dv) begin
      tx_active <= 1'b1;
      frame_cnt <= 0;
    end
    if (tx_dv) begin
      log_byte.push_back(tx_byte);
      log_gnt.push_back(oh_idx(grant));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b, input logic l);
    src_q[k].push_back({l, b});
  endtask

  function automatic bit q_all_empty();
    int s;
    s = 0;
    for (int k = 0; k < NUM_REQ; k++) s += src_q[k].size();
    return (s == 0);
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 3000) begin
      @(posedge clk); #1;
      n++;
      ok = !busy && !tx_active && q_all_empty();
    end
    chk({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_log(input string tag, input int target);
    int n;
    n = 0;
    while (log_byte.size() < target && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_log_reached"}, 32'(log_byte.size() >= target), 32'd1);
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] b, input int g);
    if (rd_ptr < log_byte.size()) begin
      chk({tag, "_byte"}, 32'(log_byte[rd_ptr]), 32'(b));
      chk({tag, "_gnt"}, log_gnt[rd_ptr], g);
    end else begin
      chk({tag, "_count"}, log_byte.size(), rd_ptr + 1);
    end
    rd_ptr++;
  endtask

  initial begin
    int  n;
    bit  ok;
    rst = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_dv", 32'(tx_dv), 32'd0);
    chk("rst_byte", 32'(tx_byte), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Req0 "AB": latency and release
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    @(posedge clk); #1;
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("t1_dv_pulse", 32'(tx_dv), 32'd1);
    chk("t1_byte", 32'(tx_byte), 32'h41);
    chk("t1_ready_send", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("t1_dv_low", 32'(tx_dv), 32'd0);
    chk("t1_byte_hold", 32'(tx_byte), 32'h41);
    wait_idle("t1");
    chk("t1_release", 32'(grant), 32'd0);
    expect_tx("t1_a", 8'h41, 0);
    expect_tx("t1_b", 8'h42, 0);
    chk("t1_count", log_byte.size(), rd_ptr);

    // rr_ptr is 1 now: Req1 beats Req0, leaving rr_ptr at 1
    push(0, 8'h5A, 1'b1);
    push(1, 8'h61, 1'b1);
    wait_idle("t1b");
    expect_tx("t1b_r1", 8'h61, 1);
    expect_tx("t1b_r0", 8'h5A, 0);
    // Req1 alone moves rr_ptr to 2
    push(1, 8'h62, 1'b1);
    wait_idle("t1c");
    expect_tx("t1c_r1", 8'h62, 1);

    // Req1 and Req3 together with rr_ptr=2: Req3 packet first, unbroken
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b1);
    push(3, 8'h33, 1'b0);
    push(3, 8'h34, 1'b1);
    wait_idle("t2");
    expect_tx("t2_r3a", 8'h33, 3);
    expect_tx("t2_r3b", 8'h34, 3);
    expect_tx("t2_r1a", 8'h31, 1);
    expect_tx("t2_r1b", 8'h32, 1);
    chk("t2_count", log_byte.size(), rd_ptr);

    // Owner Req2 stalls 50 cycles mid-packet; stray TX done while in FETCH
    push(2, 8'h50, 1'b0);
    push(2, 8'h51, 1'b0);
    push(2, 8'h52, 1'b1);
    push(0, 8'h7A, 1'b1);
    n = 0;
    while (acc_cnt[2] < 1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t3_first_accept", 32'(acc_cnt[2] >= 1), 32'd1);
    hold[2] = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (grant !== 4'b0100 || tx_dv !== 1'b0) ok = 1'b0;
      glitch_done = (i == 30);
    end
    glitch_done = 1'b0;
    chk("t3_gap_hold", 32'(ok), 32'd1);
    chk("t3_gap_lines", log_byte.size(), rd_ptr + 1);
    hold[2] = 1'b0;
    wait_idle("t3");
    expect_tx("t3_p", 8'h50, 2);
    expect_tx("t3_q", 8'h51, 2);
    expect_tx("t3_r", 8'h52, 2);
    expect_tx("t3_z", 8'h7A, 0);
    chk("t3_count", log_byte.size(), rd_ptr);

    // Reset while Req2 waits on an in-flight byte (rr_ptr was 1, would become 3)
    push(2, 8'h58, 1'b0);
    push(2, 8'h59, 1'b1);
    wait_log("t4", rd_ptr + 1);
    rst = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
    push(1, 8'h6D, 1'b1);
    push(3, 8'h6E, 1'b1);
    @(posedge clk); #1;
    chk("t4_rst_grant", 32'(grant), 32'd0);
    chk("t4_rst_ready", 32'(req_ready), 32'd0);
    chk("t4_rst_dv", 32'(tx_dv), 32'd0);
    chk("t4_rst_byte", 32'(tx_byte), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    ok = 1'b1;
    n  = 0;
    while (tx_active && n < 50) begin
      if (grant !== 4'b0000 || busy !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("t4_hold_off", 32'(ok), 32'd1);
    chk("t4_active_fell", 32'(tx_active), 32'd0);
    @(posedge clk); #1;
    chk("t4_rr_from0", 32'(grant), 32'h2);
    wait_idle("t4");
    expect_tx("t4_x", 8'h58, 2);
    expect_tx("t4_m", 8'h6D, 1);
    expect_tx("t4_n", 8'h6E, 3);
    chk("t4_count", log_byte.size(), rd_ptr);

    // Req0 single byte "f"; ready must stay low once it has been sent
    push(0, 8'h66, 1'b1);
    ok = 1'b1;
    n  = 0;
    while (!(!busy && !tx_active && q_all_empty()) && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (log_byte.size() > rd_ptr && req_ready !== 4'b0000) ok = 1'b0;
    end
    chk("t5_idle", 32'(n < 3000), 32'd1);
    chk("t5_ready_low", 32'(ok), 32'd1);
    expect_tx("t5_f", 8'h66, 0);
`ifdef UART_ARB_CRLF_EN
    expect_tx("t5_cr", 8'h0D, 0);
    expect_tx("t5_lf", 8'h0A, 0);
`endif
    chk("t5_count", log_byte.size(), rd_ptr);
    chk("t5_release", 32'(grant), 32'd0);

    // Req3 alone returns rr_ptr to 0
    push(3, 8'h77, 1'b1);
    wait_idle("t5b");
    expect_tx("t5b_w", 8'h77, 3);

    // All four continuously valid with single-byte packets: strict rotation
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < NUM_REQ; k++) push(k, 8'h80 + 8'(16 * k) + 8'(j), 1'b1);
    wait_idle("t6");
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < NUM_REQ; k++)
        expect_tx($sformatf("t6_j%0d_k%0d", j, k), 8'h80 + 8'(16 * k) + 8'(j), k);
`ifdef UART_ARB_CRLF_EN
    chk("t6_count", log_byte.size(), rd_ptr + 16);
`else
    chk("t6_count", log_byte.size(), rd_ptr);
`endif
    chk("dv_width", dv_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
